// File: rtl/pcpi_mul_seq.sv
// Sequential shift-add multiplier for the PCPI port: MUL and optionally MULH/MULHSU/MULHU.
// STEPS_AT_ONCE multiplier bits are retired per cycle; CARRY_CHAIN only changes adder structure.
module pcpi_mul_seq #(
  parameter int XLEN          = 32,
  parameter int STEPS_AT_ONCE = 1,
  parameter int CARRY_CHAIN   = 4,
  parameter int ENABLE_MULH   = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready,
  output logic            busy
);

  // state  | meaning
  // S_IDLE | waiting for a matching instruction while armed
  // S_RUN  | shift-add steps, then one cycle to load pcpi_rd
  // S_DONE | result presented for exactly one cycle

  localparam int W  = 2 * XLEN;
  localparam int CW = $clog2(W) + 1;
  localparam int CC = (CARRY_CHAIN == 0) ? 1 : CARRY_CHAIN;
  localparam logic [CW-1:0] CNT_MUL  = CW'(XLEN / STEPS_AT_ONCE - 1);
  localparam logic [CW-1:0] CNT_MULH = CW'(W / STEPS_AT_ONCE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    rs1_q, rs2_q, acc_q, acc_next, pp_sum;
  logic [CW-1:0]   cnt_q;
  logic            last_q, high_q, armed;
  logic            insn_m, is_mul, is_mulh, is_mulhsu, is_mulhu, match, start;
  logic            chunk_cy;
  logic [W-1:0]    rs1_ext, rs2_ext;
  logic [2:0]      funct3;
  logic            unused_insn;

  assign funct3      = pcpi_insn[14:12];
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  always_comb begin
    insn_m    = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
    is_mul    = insn_m && (funct3 == 3'b000);
    is_mulh   = insn_m && (funct3 == 3'b001) && (ENABLE_MULH != 0);
    is_mulhsu = insn_m && (funct3 == 3'b010) && (ENABLE_MULH != 0);
    is_mulhu  = insn_m && (funct3 == 3'b011) && (ENABLE_MULH != 0);
    match     = is_mul || is_mulh || is_mulhsu || is_mulhu;
    start     = pcpi_valid && match && armed;
    rs1_ext   = (is_mulh || is_mulhsu) ? {{XLEN{pcpi_rs1[XLEN-1]}}, pcpi_rs1}
                                       : {{XLEN{1'b0}}, pcpi_rs1};
    rs2_ext   = is_mulh ? {{XLEN{pcpi_rs2[XLEN-1]}}, pcpi_rs2}
                        : {{XLEN{1'b0}}, pcpi_rs2};
  end

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < STEPS_AT_ONCE; i++) begin
      if (rs2_q[i]) pp_sum = pp_sum + (rs1_q << i);
    end
  end

  // Accumulator add split into CARRY_CHAIN-bit chunks with the carry rippled between them.
  always_comb begin
    acc_next = acc_q + pp_sum;
    chunk_cy = 1'b0;
    if (CARRY_CHAIN != 0) begin
      for (int c = 0; c < W / CC; c++) begin
        {chunk_cy, acc_next[c*CC +: CC]} = {1'b0, acc_q[c*CC +: CC]}
                                         + {1'b0, pp_sum[c*CC +: CC]}
                                         + {{CC{1'b0}}, chunk_cy};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (!pcpi_valid) state_d = S_IDLE;
        else if (last_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pcpi_ready = (state_q == S_DONE);
    pcpi_wr    = (state_q == S_DONE);
    busy       = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      high_q    <= 1'b0;
      pcpi_rd   <= '0;
      pcpi_wait <= 1'b0;
      armed     <= 1'b1;
    end else begin
      pcpi_wait <= (state_d != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (!pcpi_valid) armed <= 1'b1;
          if (start) begin
            rs1_q  <= rs1_ext;
            rs2_q  <= rs2_ext;
            acc_q  <= '0;
            cnt_q  <= is_mul ? CNT_MUL : CNT_MULH;
            last_q <= 1'b0;
            high_q <= !is_mul;
          end
        end
        S_RUN: begin
          if (pcpi_valid) begin
            if (last_q) begin
              pcpi_rd <= high_q ? acc_q[W-1:XLEN] : acc_q[XLEN-1:0];
            end else begin
              acc_q  <= acc_next;
              rs1_q  <= rs1_q << STEPS_AT_ONCE;
              rs2_q  <= rs2_q >> STEPS_AT_ONCE;
              cnt_q  <= cnt_q - CW'(1);
              last_q <= (cnt_q == '0);
            end
          end
        end
        S_DONE:  armed <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_mul_seq.sv
// Bench for pcpi_mul_seq: three configurations share one stimulus stream and are each
// compared every cycle against an event-level model (accept, fixed latency, abort, re-arm).
module tb_pcpi_mul_seq;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] insn = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  rdy, wr, wt, bsy;
  logic [31:0] rd [3];

  always #5 clk = ~clk;

  pcpi_mul_seq #(.XLEN(32), .STEPS_AT_ONCE(1), .CARRY_CHAIN(4), .ENABLE_MULH(1)) u_s1 (
    .clk(clk), .resetn(resetn), .pcpi_valid(valid), .pcpi_insn(insn), .pcpi_rs1(rs1),
    .pcpi_rs2(rs2), .pcpi_wr(wr[0]), .pcpi_rd(rd[0]), .pcpi_wait(wt[0]),
    .pcpi_ready(rdy[0]), .busy(bsy[0]));
  pcpi_mul_seq #(.XLEN(32), .STEPS_AT_ONCE(4), .CARRY_CHAIN(0), .ENABLE_MULH(1)) u_s4 (
    .clk(clk), .resetn(resetn), .pcpi_valid(valid), .pcpi_insn(insn), .pcpi_rs1(rs1),
    .pcpi_rs2(rs2), .pcpi_wr(wr[1]), .pcpi_rd(rd[1]), .pcpi_wait(wt[1]),
    .pcpi_ready(rdy[1]), .busy(bsy[1]));
  pcpi_mul_seq #(.XLEN(32), .STEPS_AT_ONCE(1), .CARRY_CHAIN(4), .ENABLE_MULH(0)) u_nm (
    .clk(clk), .resetn(resetn), .pcpi_valid(valid), .pcpi_insn(insn), .pcpi_rs1(rs1),
    .pcpi_rs2(rs2), .pcpi_wr(wr[2]), .pcpi_rd(rd[2]), .pcpi_wait(wt[2]),
    .pcpi_ready(rdy[2]), .busy(bsy[2]));

  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0;

  int lat_mul  [3] = '{33, 9, 33};
  int lat_mulh [3] = '{65, 17, 65};
  bit en_mulh  [3] = '{1'b1, 1'b1, 1'b0};

  // model: phase 0 idle, 1 computing, 2 result cycle
  int          m_phase [3];
  int          m_left  [3];
  bit          m_armed [3];
  logic [31:0] m_res   [3];
  logic [31:0] m_rd    [3];
  int          rdy_cyc [3];
  int          rdy_cnt [3];
  logic [31:0] last_rd [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_match(input logic [31:0] i, input bit en);
    if (i[6:0] != 7'h33 || i[31:25] != 7'h01) return 1'b0;
    case (i[14:12])
      3'd0:          return 1'b1;
      3'd1, 3'd2, 3'd3: return en;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] mk_insn(input logic [2:0] f3);
    return {7'b0000001, 5'd3, 5'd2, f3, 5'd1, 7'b0110011};
  endfunction

  task automatic model_step(input int d);
    if (!resetn) begin
      m_phase[d] = 0;
      m_armed[d] = 1'b1;
      m_rd[d]    = '0;
    end else begin
      case (m_phase[d])
        2: begin
          m_phase[d] = 0;
          m_armed[d] = 1'b0;
        end
        1: begin
          if (!valid) m_phase[d] = 0;
          else begin
            m_left[d]--;
            if (m_left[d] == 0) begin
              m_phase[d] = 2;
              m_rd[d]    = m_res[d];
            end
          end
        end
        default: begin
          if (valid && m_armed[d] && is_match(insn, en_mulh[d])) begin
            m_phase[d] = 1;
            m_left[d]  = (insn[14:12] == 3'd0) ? lat_mul[d] : lat_mulh[d];
            m_res[d]   = ref_mul(insn[14:12], rs1, rs2);
          end else if (!valid) m_armed[d] = 1'b1;
        end
      endcase
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_phase[d] = 0; m_left[d] = 0; m_armed[d] = 1'b1; m_res[d] = '0; m_rd[d] = '0;
      rdy_cyc[d] = -1; rdy_cnt[d] = 0; last_rd[d] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 3; d++) begin
        model_step(d);
        check($sformatf("ready[%0d]", d), rdy[d], m_phase[d] == 2);
        check($sformatf("wr[%0d]", d),    wr[d],  m_phase[d] == 2);
        check($sformatf("wait[%0d]", d),  wt[d],  m_phase[d] != 0);
        check($sformatf("busy[%0d]", d),  bsy[d], m_phase[d] != 0);
        check($sformatf("rd[%0d]", d),    rd[d],  m_rd[d]);
        if (rdy[d] === 1'b1) begin
          rdy_cyc[d] = cyc;
          rdy_cnt[d]++;
          last_rd[d] = rd[d];
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    @(negedge clk);
    insn = mk_insn(f3); rs1 = a; rs2 = b; valid = 1'b1;
    start_cyc = cyc + 1;
    for (int d = 0; d < 3; d++) rdy_cyc[d] = -1;
    repeat (2) @(negedge clk);
    rs1 = $urandom; rs2 = $urandom;
    repeat (hold - 2) @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic directed(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_rd);
    int c0 [3];
    for (int d = 0; d < 3; d++) c0[d] = rdy_cnt[d];
    run_op(f3, a, b, 70);
    check({nm, "_rd_s1"}, last_rd[0], exp_rd);
    check({nm, "_rd_s4"}, last_rd[1], exp_rd);
    check({nm, "_lat_s1"}, rdy_cyc[0] - start_cyc, (f3 == 3'd0) ? 33 : 65);
    check({nm, "_lat_s4"}, rdy_cyc[1] - start_cyc, (f3 == 3'd0) ? 9 : 17);
    check({nm, "_once_s1"}, rdy_cnt[0] - c0[0], 1);
    check({nm, "_nm_cnt"}, rdy_cnt[2] - c0[2], (f3 == 3'd0) ? 1 : 0);
  endtask

  initial begin
    int c0, c2;
    #1;
    check("reset_ready", rdy, 3'b000);
    check("reset_wait", wt, 3'b000);
    check("reset_rd", rd[0], 32'h0);
    check("pin_mul", ref_mul(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    check("pin_mulh", ref_mul(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
    check("pin_mulhu", ref_mul(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    check("pin_mulhsu", ref_mul(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    directed("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    directed("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
    directed("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    directed("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // abort after 10 computing cycles
    c0 = rdy_cnt[0]; c2 = rdy_cnt[2];
    @(negedge clk);
    insn = mk_insn(3'd0); rs1 = 32'd123; rs2 = 32'd456; valid = 1'b1;
    repeat (11) @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    check("abort_busy_s1", bsy[0], 1'b0);
    check("abort_busy_nm", bsy[2], 1'b0);
    repeat (40) @(negedge clk);
    check("abort_noready_s1", rdy_cnt[0] - c0, 0);
    check("abort_noready_nm", rdy_cnt[2] - c2, 0);
    run_op(3'd0, 32'd1000, 32'd3000, 40);
    check("post_abort_rd", last_rd[0], 32'd3000000);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    insn = mk_insn(3'd0); rs1 = 32'd5; rs2 = 32'd6; valid = 1'b1;
    repeat (6) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("rst_busy", bsy, 3'b000);
    check("rst_wait", wt, 3'b000);
    check("rst_rd", rd[0], 32'h0);
    rs1 = 32'd9; rs2 = 32'd11;
    @(negedge clk);
    resetn = 1'b1;
    start_cyc = cyc + 1;
    repeat (40) @(negedge clk);
    check("rst_fresh_rd", last_rd[0], 32'd99);
    check("rst_fresh_lat", rdy_cyc[0] - start_cyc, 33);
    valid = 1'b0;
    repeat (2) @(negedge clk);

    // non-matching instructions: DIV funct3 and a bad opcode
    c0 = rdy_cnt[0];
    run_op(3'd4, 32'd10, 32'd3, 100);
    @(negedge clk);
    insn = mk_insn(3'd0) ^ 32'h0000_0020; valid = 1'b1;
    repeat (20) @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    check("nonmatch_noready", rdy_cnt[0] - c0, 0);

    for (int n = 0; n < 30; n++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 4));
      run_op(f3, $urandom, $urandom, $urandom_range(3, 75));
    end
    run_op(3'd1, 32'h7FFFFFFF, 32'h80000000, 70);
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 40);
    check("final_mul_rd", last_rd[1], 32'h1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
